// File: rtl/divisor_pkg.sv
// divisor_pkg: shared FSM state type and counter sizing for the sequential divider
package divisor_pkg;
  typedef enum logic [1:0] {REPOSO, CALCULO, FIN} estado_div_t;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/divisor_paso.sv
// divisor_paso: one restoring division step
//   r      partial remainder (always < d on entry)
//   bit_in next dividend bit, MSB first
//   d      divisor
//   r_next updated partial remainder
//   q_bit  quotient bit produced by this step
module divisor_paso
  import divisor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] dif;
  // The shifted remainder keeps its top bit: with d near 2^WIDTH it can exceed WIDTH bits.
  always_comb begin
    r_sh   = {r, bit_in};
    dif    = r_sh - {1'b0, d};
    q_bit  = ~dif[WIDTH];
    r_next = q_bit ? dif[WIDTH-1:0] : r_sh[WIDTH-1:0];
  end
endmodule

// File: rtl/divisor_secuencial.sv
// divisor_secuencial: iterative restoring divider with start/done handshake
//   clk, rst_n           clock, asynchronous active-low reset
//   inicio               start request, accepted while listo=1
//   dividendo, divisor   unsigned operands sampled on the accepted cycle
//   listo                idle and able to accept inicio
//   valido               one-cycle pulse when results update
//   cociente, resto      held result; divide by zero gives all ones r dividendo
//   div_cero             last operation had divisor==0
module divisor_secuencial
  import divisor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic             listo,
  output logic             valido,
  output logic [WIDTH-1:0] cociente,
  output logic [WIDTH-1:0] resto,
  output logic             div_cero
);
  localparam int CW = cnt_w(WIDTH);
  estado_div_t      estado;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [CW-1:0]    cnt;
  divisor_paso #(.WIDTH(WIDTH)) u_paso (
    .r      (rem),
    .bit_in (dvd[WIDTH-1]),
    .d      (dvs),
    .r_next (rem_next),
    .q_bit  (q_bit)
  );
  // dvd shifts dividend bits out of the top while quotient bits enter at the bottom,
  // so after WIDTH steps it holds the quotient; on the zero path it still holds the dividend.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      estado   <= REPOSO;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
      listo    <= 1'b1;
      valido   <= 1'b0;
      cociente <= '0;
      resto    <= '0;
      div_cero <= 1'b0;
    end else begin
      valido <= 1'b0;
      case (estado)
        REPOSO:
          if (inicio) begin
            dvd    <= dividendo;
            dvs    <= divisor;
            rem    <= '0;
            cnt    <= CW'(WIDTH - 1);
            listo  <= 1'b0;
            estado <= (divisor == '0) ? FIN : CALCULO;
          end
        CALCULO: begin
          dvd <= {dvd[WIDTH-2:0], q_bit};
          rem <= rem_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) estado <= FIN;
        end
        FIN: begin
          cociente <= (dvs == '0) ? '1 : dvd;
          resto    <= (dvs == '0) ? dvd : rem;
          div_cero <= (dvs == '0);
          valido   <= 1'b1;
          listo    <= 1'b1;
          estado   <= REPOSO;
        end
        default: estado <= REPOSO;
      endcase
    end
endmodule

// File: tb/tb_divisor_secuencial.sv
// tb_divisor_secuencial: self-checking bench for divisor_secuencial at WIDTH 8 and 4
module tb_divisor_secuencial;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in8 = 1'b0, in4 = 1'b0;
  logic [7:0] dd8 = '0, dv8 = '0;
  logic [3:0] dd4 = '0, dv4 = '0;
  logic       listo8, valido8, dz8, listo4, valido4, dz4;
  logic [7:0] q8, r8;
  logic [3:0] q4, r4;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  divisor_secuencial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .inicio(in8), .dividendo(dd8), .divisor(dv8),
    .listo(listo8), .valido(valido8), .cociente(q8), .resto(r8), .div_cero(dz8)
  );
  divisor_secuencial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .inicio(in4), .dividendo(dd4), .divisor(dv4),
    .listo(listo4), .valido(valido4), .cociente(q4), .resto(r4), .div_cero(dz4)
  );

  task automatic go8(input logic [7:0] a, input logic [7:0] b);
    dd8 = a; dv8 = b; in8 = 1'b1;
    @(posedge clk); #1;
    in8 = 1'b0;
  endtask

  // n counts cycles from the inicio cycle to the valido cycle; lo counts listo-low cycles
  task automatic wait8(output int n, output int lo);
    n = 1;
    lo = listo8 ? 0 : 1;
    do begin
      @(posedge clk); #1;
      n++;
      if (!listo8) lo++;
    end while (!valido8 && n < 60);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({listo8, valido8, q8, r8, dz8} !== {1'b1, 1'b0, 16'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset8 got listo=%b valido=%b q=%0d r=%0d z=%b want 1 0 0 0 0", listo8, valido8, q8, r8, dz8);
    end
    total++;
    if ({listo4, valido4, q4, r4, dz4} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset4 got listo=%b valido=%b q=%0d r=%0d z=%b want 1 0 0 0 0", listo4, valido4, q4, r4, dz4);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int n, lo;
    go8(8'd100, 8'd7);
    wait8(n, lo);
    total++;
    if ({q8, r8, dz8} !== {8'd14, 8'd2, 1'b0}) begin
      bad++;
      $display("FAIL basic_result got %0d r %0d z=%b want 14 r 2 z=0", q8, r8, dz8);
    end
    total++;
    if (n !== 10) begin bad++; $display("FAIL basic_latency got %0d want 10", n); end
    total++;
    if (lo !== 9) begin bad++; $display("FAIL basic_listo_low got %0d want 9", lo); end
    @(posedge clk); #1;
    total++;
    if (valido8 !== 1'b0) begin bad++; $display("FAIL basic_pulse_width got valido=%b want 0", valido8); end
  endtask

  task automatic test_div_zero();
    int n, lo;
    go8(8'd37, 8'd0);
    wait8(n, lo);
    total++;
    if ({q8, r8, dz8} !== {8'd255, 8'd37, 1'b1}) begin
      bad++;
      $display("FAIL zero_result got %0d r %0d z=%b want 255 r 37 z=1", q8, r8, dz8);
    end
    total++;
    if (n !== 2) begin bad++; $display("FAIL zero_latency got %0d want 2", n); end
    go8(8'd9, 8'd3);
    wait8(n, lo);
    total++;
    if ({q8, r8, dz8} !== {8'd3, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL after_zero got %0d r %0d z=%b want 3 r 0 z=0", q8, r8, dz8);
    end
  endtask

  task automatic test_ignore_busy();
    int n, lo, pulses;
    go8(8'd200, 8'd10);
    repeat (3) @(posedge clk);
    #1;
    dd8 = 8'd77; dv8 = 8'd3; in8 = 1'b1;
    total++;
    if ({q8, r8} !== {8'd3, 8'd0}) begin
      bad++;
      $display("FAIL hold_during_calc got %0d r %0d want 3 r 0", q8, r8);
    end
    repeat (2) @(posedge clk);
    #1;
    in8 = 1'b0; dd8 = 8'd1; dv8 = 8'd1;
    wait8(n, lo);
    total++;
    if ({q8, r8, dz8} !== {8'd20, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL busy_result got %0d r %0d z=%b want 20 r 0 z=0", q8, r8, dz8);
    end
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (valido8) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL busy_extra_valido got %0d want 0", pulses); end
  endtask

  task automatic test_reset_mid();
    int n, lo, pulses;
    go8(8'd255, 8'd16);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({listo8, valido8, q8, r8, dz8} !== {1'b1, 1'b0, 16'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid got listo=%b valido=%b q=%0d r=%0d z=%b want 1 0 0 0 0", listo8, valido8, q8, r8, dz8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (valido8) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL reset_mid_valido got %0d want 0", pulses); end
    go8(8'd255, 8'd16);
    wait8(n, lo);
    total++;
    if ({q8, r8, dz8} !== {8'd15, 8'd15, 1'b0}) begin
      bad++;
      $display("FAIL reset_rerun got %0d r %0d z=%b want 15 r 15 z=0", q8, r8, dz8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [4];
    logic [7:0] pb [4];
    logic [7:0] eq, er;
    int n, lo, prev;
    pa = '{8'd5, 8'd0, 8'd255, 8'd255};
    pb = '{8'd9, 8'd3, 8'd255, 8'd1};
    prev = 0;
    dd8 = pa[0]; dv8 = pb[0]; in8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k < 3) begin dd8 = pa[k+1]; dv8 = pb[k+1]; end
      else in8 = 1'b0;
      wait8(n, lo);
      eq = pa[k] / pb[k];
      er = pa[k] % pb[k];
      total++;
      if ({q8, r8, dz8} !== {eq, er, 1'b0}) begin
        bad++;
        $display("FAIL b2b_result[%0d] got %0d r %0d z=%b want %0d r %0d z=0", k, q8, r8, dz8, eq, er);
      end
      if (k > 0) begin
        total++;
        if (cyc - prev !== 10) begin bad++; $display("FAIL b2b_spacing[%0d] got %0d want 10", k, cyc - prev); end
      end
      prev = cyc;
    end
  endtask

  task automatic test_random8();
    logic [7:0] a, b, eq, er;
    int n, lo;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 8 == 0) ? 8'd0 : (i % 5 == 0) ? 8'($urandom_range(1, 4)) : 8'($urandom_range(0, 255));
      eq = (b == 0) ? 8'hFF : a / b;
      er = (b == 0) ? a : a % b;
      go8(a, b);
      dd8 = 8'($urandom); dv8 = 8'($urandom);
      wait8(n, lo);
      total++;
      if ({q8, r8, dz8} !== {eq, er, b == 0}) begin
        bad++;
        $display("FAIL rand8 %0d/%0d got %0d r %0d z=%b want %0d r %0d z=%b", a, b, q8, r8, dz8, eq, er, b == 0);
      end
      total++;
      if (n !== ((b == 0) ? 2 : 10)) begin bad++; $display("FAIL rand8_latency %0d/%0d got %0d want %0d", a, b, n, (b == 0) ? 2 : 10); end
    end
  endtask

  task automatic test_exhaustive4();
    logic [3:0] eq, er;
    int n;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        dd4 = 4'(a); dv4 = 4'(b); in4 = 1'b1;
        @(posedge clk); #1;
        in4 = 1'b0;
        n = 1;
        do begin
          @(posedge clk); #1;
          n++;
        end while (!valido4 && n < 40);
        eq = (b == 0) ? 4'hF : 4'(a / b);
        er = (b == 0) ? 4'(a) : 4'(a % b);
        total++;
        if ({q4, r4, dz4} !== {eq, er, b == 0}) begin
          bad++;
          $display("FAIL exh4 %0d/%0d got %0d r %0d z=%b want %0d r %0d z=%b", a, b, q4, r4, dz4, eq, er, b == 0);
        end
        total++;
        if (n !== ((b == 0) ? 2 : 6)) begin bad++; $display("FAIL exh4_latency %0d/%0d got %0d want %0d", a, b, n, (b == 0) ? 2 : 6); end
      end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random8();
    test_exhaustive4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
